// File: rtl/db_scan_ctrl.sv
// Multi-button debounce controller: one shared sample-tick divider, a 2-flop
// synchronizer and a confirm FSM per channel, registered level and edge pulses.
module db_scan_ctrl #(
    parameter int N        = 4,
    parameter int TICK_DIV = 1_000_000,
    parameter int CONFIRM  = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     sw,
    output logic [N-1:0]     db_level,
    output logic [N-1:0]     db_rise,
    output logic [N-1:0]     db_fall,
    output logic             sample_tick,
    output logic [2*N-1:0]   dbg_state
);

    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(CONFIRM + 1);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    logic [N-1:0]  sw_meta_q;
    logic [N-1:0]  sw_s_q;
    logic [DW-1:0] div_cnt_q;
    logic          tick_q;
    state_t        state_q [N];
    state_t        state_d [N];
    logic [CW-1:0] cnt_q   [N];
    logic [CW-1:0] cnt_d   [N];
    logic [N-1:0]  level_q, level_d;
    logic [N-1:0]  rise_q, rise_d;
    logic [N-1:0]  fall_q, fall_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sw_meta_q <= '0;
            sw_s_q    <= '0;
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            level_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= ZERO;
                cnt_q[i]   <= '0;
            end
        end else begin
            sw_meta_q <= sw;
            sw_s_q    <= sw_meta_q;
            if (div_cnt_q == DW'(TICK_DIV - 1)) begin
                div_cnt_q <= '0;
            end else begin
                div_cnt_q <= div_cnt_q + DW'(1);
            end
            // Tick lands the cycle after the terminal count, giving an exact TICK_DIV period.
            tick_q  <= (div_cnt_q == DW'(TICK_DIV - 1));
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        level_d   = '0;
        rise_d    = '0;
        fall_d    = '0;
        dbg_state = '0;
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            // An input reversal aborts the wait before any tick is considered.
            case (state_q[i])
                ZERO: begin
                    if (sw_s_q[i]) begin
                        state_d[i] = WAIT1;
                        cnt_d[i]   = CW'(CONFIRM - 1);
                    end
                end
                WAIT1: begin
                    if (!sw_s_q[i]) begin
                        state_d[i] = ZERO;
                    end else if (tick_q) begin
                        if (cnt_q[i] == '0) state_d[i] = ONE;
                        else                cnt_d[i]   = cnt_q[i] - CW'(1);
                    end
                end
                ONE: begin
                    if (!sw_s_q[i]) begin
                        state_d[i] = WAIT0;
                        cnt_d[i]   = CW'(CONFIRM - 1);
                    end
                end
                WAIT0: begin
                    if (sw_s_q[i]) begin
                        state_d[i] = ONE;
                    end else if (tick_q) begin
                        if (cnt_q[i] == '0) state_d[i] = ZERO;
                        else                cnt_d[i]   = cnt_q[i] - CW'(1);
                    end
                end
            endcase
            level_d[i] = (state_d[i] == ONE) || (state_d[i] == WAIT0);
            rise_d[i]  = (state_q[i] == WAIT1) && (state_d[i] == ONE);
            fall_d[i]  = (state_q[i] == WAIT0) && (state_d[i] == ZERO);
            dbg_state[2*i +: 2] = state_q[i];
        end
    end

    assign db_level    = level_q;
    assign db_rise     = rise_q;
    assign db_fall     = fall_q;
    assign sample_tick = tick_q;

endmodule

// File: tb/tb_db_scan_ctrl.sv
// Bench for db_scan_ctrl (N=2, TICK_DIV=4, CONFIRM=3): directed stimulus pushes
// expected pulse events; a negedge monitor pops and compares them.
module tb_db_scan_ctrl;

    localparam int N  = 2;
    localparam int TD = 4;
    localparam int CF = 3;
    localparam int EW = 38;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic [N-1:0] sw = '0;
    logic [N-1:0] db_level, db_rise, db_fall;
    logic         sample_tick;
    logic [2*N-1:0] dbg_state;

    int           rel_cyc;
    int           total = 0;
    int           bad = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_e;
    logic [N-1:0] prev_level = '0;

    db_scan_ctrl #(.N(N), .TICK_DIV(TD), .CONFIRM(CF)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sw          (sw),
        .db_level    (db_level),
        .db_rise     (db_rise),
        .db_fall     (db_fall),
        .sample_tick (sample_tick),
        .dbg_state   (dbg_state)
    );

    // Clock / reset-relative cycle count
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rel_cyc <= 0;
        else          rel_cyc <= rel_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, rel_cyc);
        end
    endtask

    // Driver tasks
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called right after driving sw: the first sampling edge is rel_cyc+1 and
    // the accepted change must appear 11..14 cycles after it.
    task automatic expect_change(input logic [1:0] r, input logic [1:0] f, input logic [1:0] l);
        logic [15:0] lo, hi;
        lo = 16'(rel_cyc + 12);
        hi = 16'(rel_cyc + 15);
        exp_q.push_back({r, f, l, lo, hi});
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!reset_n) begin
            check("reset_outputs", 32'({db_level, db_rise, db_fall, sample_tick}), 32'd0);
            prev_level = '0;
        end else begin
            check("sample_tick", 32'(sample_tick), 32'(rel_cyc != 0 && (rel_cyc % TD) == 0));
            check("pulse_level",
                  32'((db_rise & ~db_level) | (db_fall & db_level) |
                      (db_level ^ prev_level ^ (db_rise | db_fall))), 32'd0);
            if ((db_rise | db_fall) != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 32'({db_rise, db_fall}), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rise",  32'(db_rise),  32'(mon_e[37:36]));
                    check("fall",  32'(db_fall),  32'(mon_e[35:34]));
                    check("level", 32'(db_level), 32'(mon_e[33:32]));
                    total++;
                    if (rel_cyc < int'(mon_e[31:16]) || rel_cyc > int'(mon_e[15:0])) begin
                        bad++;
                        $display("FAIL latency: pulse at cycle %0d expected window %0d..%0d",
                                 rel_cyc, mon_e[31:16], mon_e[15:0]);
                    end
                end
            end
            prev_level = db_level;
        end
    end

    // Stimulus
    initial begin
        #1 reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        step(12);

        sw = 2'b01;
        expect_change(2'b01, 2'b00, 2'b01);
        step(20);

        sw = 2'b00;
        step(5);
        sw = 2'b01;
        step(20);

        sw = 2'b00;
        expect_change(2'b00, 2'b01, 2'b00);
        step(20);

        for (int i = 0; i < 8; i++) begin
            sw = (i % 2 == 0) ? 2'b01 : 2'b00;
            step(3);
        end
        sw = 2'b01;
        expect_change(2'b01, 2'b00, 2'b01);
        step(20);

        sw = 2'b00;
        expect_change(2'b00, 2'b01, 2'b00);
        step(20);
        sw = 2'b11;
        expect_change(2'b11, 2'b00, 2'b11);
        step(20);
        sw = 2'b00;
        expect_change(2'b00, 2'b11, 2'b00);
        step(20);

        sw = 2'b10;
        expect_change(2'b10, 2'b00, 2'b10);
        step(20);
        sw = 2'b11;
        step(7);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset", 32'({db_level, db_rise, db_fall, sample_tick}), 32'd0);
        sw = 2'b01;
        step(3);
        reset_n = 1'b1;
        expect_change(2'b01, 2'b00, 2'b01);
        step(20);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
